// File: rtl/console_rx_fifo.sv
// Console UART receiver: 8N1 deserialiser feeding a small byte FIFO that the CPU
// reads through a register interface; reads return 0 while nothing is pending.
module console_rx_fifo #(
  parameter int          DEPTH_LOG2  = 3,
  parameter logic [31:0] DEFAULT_DIV = 32'd53333
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ser_rx,
  input  logic [3:0]            i_reg_div_we,
  input  logic [31:0]           i_reg_div_di,
  output logic [31:0]           o_reg_div_do,
  input  logic                  i_reg_dat_re,
  output logic [31:0]           o_reg_dat_do,
  input  logic                  i_reg_sts_re,
  output logic [DEPTH_LOG2:0]   o_rx_count,
  output logic                  o_overrun,
  output logic                  o_frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic                  r_sync1;
  logic                  r_sync2;
  logic [31:0]           r_div;
  logic [31:0]           r_bit_div;
  logic [31:0]           r_cnt;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  state_t                r_state;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;
  logic                  r_frame_err;

  logic                  w_rx_s;
  logic [31:0]           w_eff_div;
  logic                  w_cnt_tick;
  state_t                w_state_nxt;
  logic [31:0]           w_cnt_nxt;
  logic [31:0]           w_bit_div_nxt;
  logic [2:0]            w_bit_idx_nxt;
  logic [7:0]            w_shift_nxt;
  logic                  w_push_req;
  logic                  w_ferr_set;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic                  w_ovr_set;

  assign w_rx_s     = r_sync2;
  assign w_eff_div  = (r_div < 32'd4) ? 32'd4 : r_div;
  // The counter expires on the cycle it would decrement to zero, so one period is exactly bit_div clocks.
  assign w_cnt_tick = (r_cnt == 32'd1);

  // Two-flop synchroniser for the asynchronous serial pin, preset to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_ser_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Divider register with per-byte-lane write enables.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= DEFAULT_DIV;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_reg_div_we[b]) begin
          r_div[8*b +: 8] <= i_reg_div_di[8*b +: 8];
        end
      end
    end
  end

  // Receiver FSM state and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 32'd0;
      r_bit_div <= 32'd4;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_div <= w_bit_div_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Receiver FSM next-state logic: mid-bit sampling of start, data and stop bits.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_div_nxt = r_bit_div;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push_req    = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_bit_div_nxt = w_eff_div;
          w_cnt_nxt     = w_eff_div >> 1;
          w_state_nxt   = ST_START;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_cnt_tick) begin
          if (w_rx_s) begin
            w_state_nxt   = ST_IDLE;
          end else begin
            w_cnt_nxt     = r_bit_div;
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = ST_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      ST_DATA: begin
        if (w_cnt_tick) begin
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_cnt_nxt              = r_bit_div;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      ST_STOP: begin
        if (w_cnt_tick) begin
          if (w_rx_s) begin
            w_push_req  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before another start bit is accepted.
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BREAK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_pop_ok  = i_reg_dat_re && !w_empty;
  // When full, a same-cycle pop frees the head slot that the push then reuses.
  assign w_push_ok = w_push_req && (!w_full || w_pop_ok);
  assign w_ovr_set = w_push_req && w_full && !w_pop_ok;

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= r_shift;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a set event in the clearing cycle takes priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (i_reg_sts_re) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (i_reg_sts_re) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign o_reg_div_do = r_div;
  assign o_reg_dat_do = w_empty ? 32'h0 : {24'h0, r_mem[r_rd_ptr[DEPTH_LOG2-1:0]]};
  assign o_rx_count   = r_count;
  assign o_overrun    = r_overrun;
  assign o_frame_err  = r_frame_err;

endmodule

// File: doc/console_rx_fifo.md
Name: console_rx_fifo

Overview:
- Receive-side UART peripheral for the console.
- Deserialises 8N1 frames from the serial input pin into a small byte FIFO.
- Answers the CPU's register read interface: the CPU samples `reg_dat_do` and pulses `reg_dat_re` to consume the byte.
- Returns a 0 word when no data is pending, so the CPU's non-blocking console-read instruction can run against it unchanged.

Parameters:
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 bytes (8).
- DEFAULT_DIV, 53333, bit period in clk cycles after reset (300 baud at 16 MHz).

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  synchronous, active-high reset.
- ser_rx  in  1  asynchronous serial input; idle high.
- reg_div_we  in  4  byte enables for divider write; bit n writes byte n.
- reg_div_di  in  32  divider write data.
- reg_div_do  out  32  current divider value.
- reg_dat_re  in  1  pop strobe; one pop per high cycle.
- reg_dat_do  out  32  {24'b0, FIFO head} when not empty, else 32'h0.
- reg_sts_re  in  1  clears sticky error flags.
- rx_count  out  DEPTH_LOG2+1  bytes currently held.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: the stop bit sampled low.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high, on `rst`.
- Reset values:
  - divider = DEFAULT_DIV.
  - FIFO empty: rd_ptr = wr_ptr = 0, rx_count = 0.
  - `reg_dat_do` = 0, `overrun` = 0, `frame_err` = 0.
  - FSM in IDLE; sync chain preset to 1.
  - A reset mid-frame abandons the frame with no push.
- Input synchroniser: `ser_rx` passes through a 2-flop synchroniser, giving `rx_s`. All decisions use `rx_s`.
- Divider register:
  - Byte-lane writes apply on the same edge; `reg_div_do` shows the new value the next cycle.
  - The effective period is max(divider, 4).
  - The period is latched into `bit_div` on entry to START. A divider write mid-frame affects only the next frame.
- FSM:
  - IDLE: when `rx_s`==0, load cnt = bit_div/2 (integer divide) and go to START.
  - START: decrement cnt; at cnt==0 re-sample. If `rx_s`==1, false start, back to IDLE. Otherwise load cnt = bit_div, bit_idx = 0, go to DATA.
  - DATA: decrement cnt; at cnt==0 shift `rx_s` into shift[bit_idx] (LSB first) and reload cnt = bit_div. After bit_idx==7, go to STOP.
  - STOP: at cnt==0 sample.
    - `rx_s`==1: push shift and go to IDLE.
    - `rx_s`==0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- FIFO:
  - Push occurs on the stop-sample edge. The byte appears on `reg_dat_do` one cycle after the stop-sample cycle if the FIFO was empty.
  - `reg_dat_do` is combinational from the head entry and the empty flag.
  - Pop on `reg_dat_re` when not empty advances rd_ptr. Pop when empty has no effect.
  - Pointers are DEPTH_LOG2+1 bits and wrap naturally. full = (MSBs differ and lower bits equal).
  - Push when full with no pop: byte dropped, `overrun` set, contents unchanged.
  - Simultaneous push and pop when full: both happen, no overrun, count unchanged.
  - Simultaneous push and pop when empty: the pop is ignored, the push lands, count = 1.
- Sticky flags: `reg_sts_re` clears both flags. A set event in the same cycle as the clear wins, leaving the flag at 1.
- Width rules: cnt is 32 bits; rx_count ranges 0..2**DEPTH_LOG2.

Test Plan:
- Reset, then check outputs. After `rst` is released: `reg_div_do`=53333, `reg_dat_do`=0, rx_count=0, both flags 0.
- Single byte. Write divider=16 (`reg_div_we`=4'b1111), then send 8N1 0x41 at 16 clk/bit.
  - Expected: `reg_dat_do`=32'h41 one cycle after the stop sample, rx_count=1.
  - One `reg_dat_re` pulse gives `reg_dat_do`=0 and rx_count=0.
- Overrun. With div=16, send 9 bytes 0x01..0x09 without popping.
  - Expected: rx_count=8, `overrun`=1.
  - Popping 8 times yields 0x01..0x08 in order; afterwards `reg_dat_do`=0.
  - Pulsing `reg_sts_re` clears `overrun`.
- Frame error and glitch rejection.
  - Send 0x55 with the stop bit low: no push, `frame_err`=1, FSM stays in BREAK until the line goes high.
  - A 3-cycle low glitch at div=16: no push, no flag.
- Full with simultaneous push and pop. Fill to 8 bytes, then assert `reg_dat_re` on the exact cycle a ninth byte 0xAA stop-samples.
  - Expected: rx_count stays 8, `overrun`=0, 0xAA is the last byte popped.
- Divider write mid-frame and clamp.
  - Writing div=32 during a div=16 frame still receives that frame correctly at 16; the next frame at 32 is received correctly.
  - Writing div=2 results in an effective period of 4 clk/bit.
